// File: rtl/psram_xfer_seq_if.sv
// psram_xfer_seq_if -- user-side bus of the octal PSRAM transfer sequencer.
//   Request : req_valid_i/req_ready_o handshake, req_wr_i, req_addr_i[31:0],
//             req_len_i[7:0] (words - 1)
//   Write   : wr_data_i[15:0], wr_valid_i, wr_ready_o
//   Read    : rd_data_o[15:0], rd_valid_o (no backpressure)
//   Status  : done_o (one-cycle pulse), err_o (sticky)
// Modports: master = requester, slave = sequencer.
interface psram_xfer_seq_if;
  logic        req_valid_i;
  logic        req_ready_o;
  logic        req_wr_i;
  logic [31:0] req_addr_i;
  logic [7:0]  req_len_i;
  logic [15:0] wr_data_i;
  logic        wr_valid_i;
  logic        wr_ready_o;
  logic [15:0] rd_data_o;
  logic        rd_valid_o;
  logic        done_o;
  logic        err_o;

  modport master (
    output req_valid_i, req_wr_i, req_addr_i, req_len_i, wr_data_i, wr_valid_i,
    input  req_ready_o, wr_ready_o, rd_data_o, rd_valid_o, done_o, err_o
  );

  modport slave (
    input  req_valid_i, req_wr_i, req_addr_i, req_len_i, wr_data_i, wr_valid_i,
    output req_ready_o, wr_ready_o, rd_data_o, rd_valid_o, done_o, err_o
  );
endinterface

// File: rtl/psram_xfer_seq.sv
// psram_xfer_seq -- octal DDR PSRAM transfer sequencer.
// One byte moves on DQ per clk_i cycle; SCK = clk_i/2, so each SCK edge
// carries one byte. Sequence: IDLE -> CMD(2) -> ADDR(4) -> LAT(2*LAT_CYC)
// -> DATA -> END(CE_HOLD) -> IDLE.
// Ports:
//   clk_i, rst_n_i        core clock, async active-low reset
//   bus (slave modport)   request / write stream / read stream / status
//   psram_sck_o           PSRAM clock
//   psram_ce_o            CE#, active low
//   psram_io_*            octal DQ pad out / enable / in
//   psram_dqs_*           DQS/DM pad out / enable / in
// Parameters: LAT_CYC (SCK periods of latency), CE_HOLD (clk_i cycles CE#
// high after a transfer), TMO_CYC (read timeout in clk_i cycles).
// Optional feature: define PSRAM_XFER_TIMEOUT_EN to abort a read that sees
// no DQS edge for TMO_CYC cycles (sets err_o). Default build waits forever.
module psram_xfer_seq #(
  parameter int LAT_CYC = 5,
  parameter int CE_HOLD = 2,
  parameter int TMO_CYC = 64
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  psram_xfer_seq_if.slave     bus,
  output logic                psram_sck_o,
  output logic                psram_ce_o,
  output logic [7:0]          psram_io_out_o,
  output logic [7:0]          psram_io_en_o,
  input  logic [7:0]          psram_io_in_i,
  output logic                psram_dqs_out_o,
  output logic                psram_dqs_en_o,
  input  logic                psram_dqs_in_i
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_CMD  = 3'd1;
  localparam logic [2:0] S_ADDR = 3'd2;
  localparam logic [2:0] S_LAT  = 3'd3;
  localparam logic [2:0] S_DATA = 3'd4;
  localparam logic [2:0] S_END  = 3'd5;

  localparam logic [15:0] LAT_LAST  = 16'(2 * LAT_CYC - 1);
  localparam logic [15:0] HOLD_LAST = 16'(CE_HOLD - 1);

  logic [2:0]  state;
  logic [15:0] cnt;
  logic        wr_q;
  logic [31:0] addr_q;
  logic [7:0]  len_q;
  logic [7:0]  word_cnt;
  logic        byte_ph;     // 0 = high byte of current word, 1 = low byte
  logic [7:0]  wd_lo_q;     // low byte of the write word taken in phase 0
  logic [7:0]  rd_hi_q;
  logic [15:0] rd_data_q;
  logic        rd_valid_q;
  logic        err_q;
  logic        sck_q;
  logic        dqs_prev_q;

  logic active, accept, dqs_edge, rd_data_st, underrun, tmo_hit, last_word;

  assign active     = (state == S_CMD) || (state == S_ADDR) ||
                      (state == S_LAT) || (state == S_DATA);
  assign accept     = (state == S_IDLE) && bus.req_valid_i;
  assign dqs_edge   = psram_dqs_in_i != dqs_prev_q;
  assign rd_data_st = (state == S_DATA) && !wr_q;
  assign underrun   = (state == S_DATA) && wr_q && !byte_ph && !bus.wr_valid_i;
  assign last_word  = word_cnt == len_q;

`ifdef PSRAM_XFER_TIMEOUT_EN
  logic [15:0] tmo_cnt;
  // Counts consecutive read-DATA cycles without a DQS edge.
  assign tmo_hit = rd_data_st && !dqs_edge && (tmo_cnt == 16'(TMO_CYC - 1));
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)                    tmo_cnt <= '0;
    else if (rd_data_st && !dqs_edge) tmo_cnt <= tmo_cnt + 16'd1;
    else                             tmo_cnt <= '0;
  end
`else
  assign tmo_hit = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state      <= S_IDLE;
      cnt        <= '0;
      wr_q       <= 1'b0;
      addr_q     <= '0;
      len_q      <= '0;
      word_cnt   <= '0;
      byte_ph    <= 1'b0;
      wd_lo_q    <= '0;
      rd_hi_q    <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      sck_q      <= 1'b0;
      dqs_prev_q <= 1'b0;
    end else begin
      rd_valid_q <= 1'b0;
      dqs_prev_q <= psram_dqs_in_i;
      // Starts at 0 on the first CMD cycle since it is held low in IDLE.
      sck_q      <= active ? ~sck_q : 1'b0;
      case (state)
        S_IDLE: if (accept) begin
          wr_q     <= bus.req_wr_i;
          addr_q   <= bus.req_addr_i;
          len_q    <= bus.req_len_i;
          cnt      <= '0;
          word_cnt <= '0;
          byte_ph  <= 1'b0;
          state    <= S_CMD;
        end
        S_CMD: begin
          cnt <= (cnt == 16'd1) ? '0 : cnt + 16'd1;
          if (cnt == 16'd1) state <= S_ADDR;
        end
        S_ADDR: begin
          cnt <= (cnt == 16'd3) ? '0 : cnt + 16'd1;
          if (cnt == 16'd3) state <= S_LAT;
        end
        S_LAT: begin
          cnt <= (cnt == LAT_LAST) ? '0 : cnt + 16'd1;
          if (cnt == LAT_LAST) state <= S_DATA;
        end
        S_DATA: begin
          if (wr_q) begin
            if (!byte_ph) begin
              if (!bus.wr_valid_i) begin
                state <= S_END;
                cnt   <= '0;
              end else begin
                wd_lo_q <= bus.wr_data_i[7:0];
                byte_ph <= 1'b1;
              end
            end else begin
              byte_ph <= 1'b0;
              if (last_word) begin
                state <= S_END;
                cnt   <= '0;
              end else begin
                word_cnt <= word_cnt + 8'd1;
              end
            end
          end else if (dqs_edge) begin
            if (!byte_ph) begin
              rd_hi_q <= psram_io_in_i;
              byte_ph <= 1'b1;
            end else begin
              rd_data_q  <= {rd_hi_q, psram_io_in_i};
              rd_valid_q <= 1'b1;
              byte_ph    <= 1'b0;
              if (last_word) begin
                state <= S_END;
                cnt   <= '0;
              end else begin
                word_cnt <= word_cnt + 8'd1;
              end
            end
          end else if (tmo_hit) begin
            state <= S_END;
            cnt   <= '0;
          end
        end
        S_END: begin
          cnt <= (cnt == HOLD_LAST) ? '0 : cnt + 16'd1;
          if (cnt == HOLD_LAST) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Error is sticky; a new acceptance clears it but a same-cycle set wins.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)                err_q <= 1'b0;
    else if (underrun || tmo_hit) err_q <= 1'b1;
    else if (accept)             err_q <= 1'b0;
  end

  // Pad outputs are decoded from registered state so reset takes effect
  // on the pads immediately.
  always_comb begin
    psram_io_out_o = 8'h00;
    case (state)
      S_CMD:  psram_io_out_o = wr_q ? 8'h80 : 8'h00;
      S_ADDR: case (cnt[1:0])
        2'd0:    psram_io_out_o = addr_q[31:24];
        2'd1:    psram_io_out_o = addr_q[23:16];
        2'd2:    psram_io_out_o = addr_q[15:8];
        default: psram_io_out_o = addr_q[7:0];
      endcase
      // High byte goes out the same cycle the word is taken.
      S_DATA: if (wr_q) psram_io_out_o = byte_ph ? wd_lo_q : bus.wr_data_i[15:8];
      default: psram_io_out_o = 8'h00;
    endcase
  end

  assign psram_ce_o      = ~active;
  assign psram_sck_o     = active & sck_q;
  assign psram_io_en_o   = ((state == S_CMD) || (state == S_ADDR) ||
                            ((state == S_DATA) && wr_q)) ? 8'hFF : 8'h00;
  assign psram_dqs_en_o  = (state == S_DATA) && wr_q;
  assign psram_dqs_out_o = 1'b0;

  assign bus.req_ready_o = state == S_IDLE;
  assign bus.wr_ready_o  = (state == S_DATA) && wr_q && !byte_ph;
  assign bus.rd_data_o   = rd_data_q;
  assign bus.rd_valid_o  = rd_valid_q;
  assign bus.done_o      = (state == S_END) && (cnt == HOLD_LAST);
  assign bus.err_o       = err_q;

endmodule
